// File: rtl/joystick_beep_trigger.sv
// Button conditioner for the buzzer path: 2-FF sync, debounce FSM, press/release strobes
// and a fixed-length beep enable. Define JOYSTICK_REPEAT_EN for auto-repeat while held.
module joystick_beep_trigger #(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
   parameter int unsigned BEEP_CYCLES     = 5_000_000,
   parameter bit          ACTIVE_LOW_IN   = 1'b1,
   parameter int unsigned REPEAT_CYCLES   = 25_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic joystick_raw,
   output logic joystick,
   output logic pressed,
   output logic press_pulse,
   output logic release_pulse
);

   localparam int unsigned CNT_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int unsigned BCNT_W = (BEEP_CYCLES > 1) ? $clog2(BEEP_CYCLES) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [BCNT_W-1:0] BEEP_LAST = BCNT_W'(BEEP_CYCLES - 1);
   localparam logic IDLE_LVL = ACTIVE_LOW_IN;

   if (DEBOUNCE_CYCLES == 0 || BEEP_CYCLES == 0 || REPEAT_CYCLES == 0) begin : g_bad_params
      $error("joystick_beep_trigger: cycle parameters must be nonzero");
   end

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DEB_PRESS,
      ST_HELD,
      ST_DEB_RELEASE
   } state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
   logic                sync1_q, sync2_q;
   logic                btn;
   logic                joy_d, pressed_d, press_d, release_d;
   logic                repeat_fire;

   // Synchroniser resets to the released pin level so reset never looks like a press
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= IDLE_LVL;
         sync2_q <= IDLE_LVL;
      end else begin
         sync1_q <= joystick_raw;
         sync2_q <= sync1_q;
      end
   end

   assign btn = ACTIVE_LOW_IN ? ~sync2_q : sync2_q;

`ifdef JOYSTICK_REPEAT_EN
   localparam int unsigned RCNT_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
   localparam logic [RCNT_W-1:0] REP_LAST = RCNT_W'(REPEAT_CYCLES - 1);

   logic [RCNT_W-1:0] rcnt_q, rcnt_d;

   // Repeat timer only runs while steadily held; any other state parks it at zero
   always_comb begin
      rcnt_d      = '0;
      repeat_fire = 1'b0;
      if (state_q == ST_HELD && btn) begin
         if (rcnt_q == REP_LAST) begin
            repeat_fire = 1'b1;
         end else begin
            rcnt_d = rcnt_q + RCNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rcnt_q <= '0;
      end else begin
         rcnt_q <= rcnt_d;
      end
   end
`else
   assign repeat_fire = 1'b0;
`endif

   // Debounce FSM, beep timer and registered-output next values
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      bcnt_d    = bcnt_q;
      joy_d     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (btn) begin
               state_d = ST_DEB_PRESS;
               cnt_d   = '0;
            end
         end
         ST_DEB_PRESS: begin
            if (!btn) begin
               state_d = ST_IDLE;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_HELD;
               press_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_HELD: begin
            if (!btn) begin
               state_d = ST_DEB_RELEASE;
               cnt_d   = '0;
            end else if (repeat_fire) begin
               press_d = 1'b1;
            end
         end
         ST_DEB_RELEASE: begin
            if (btn) begin
               state_d = ST_HELD;
            end else if (cnt_q == CNT_LAST) begin
               state_d   = ST_IDLE;
               release_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      pressed_d = (state_d == ST_HELD) || (state_d == ST_DEB_RELEASE);

      // A new press reloads the window, so back-to-back beeps merge with no gap
      if (press_d) begin
         bcnt_d = BEEP_LAST;
         joy_d  = 1'b1;
      end else if (bcnt_q != '0) begin
         bcnt_d = bcnt_q - BCNT_W'(1);
         joy_d  = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         bcnt_q        <= '0;
         joystick      <= 1'b0;
         pressed       <= 1'b0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         bcnt_q        <= bcnt_d;
         joystick      <= joy_d;
         pressed       <= pressed_d;
         press_pulse   <= press_d;
         release_pulse <= release_d;
      end
   end

endmodule
